// File: rtl/port_bridge.sv
// rtl/port_bridge.sv - CPU OUT/IN port bridge with TX FIFO and 2-entry RX buffer
//
// Purpose:
//   Connects the CPU OUT and IN instructions to a pair of host channels.
//   TX path: the CPU OUT strobe feeds a DEPTH-entry show-ahead FIFO that
//   drains to the host on a valid/ready handshake. A write into a full FIFO
//   with no drain in the same cycle is dropped and sets the sticky ovf flag.
//   RX path: host words land in a two-entry head/tail buffer. The CPU IN
//   instruction reads the head, and the in_rd strobe consumes it.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-low reset
//   out_we    in   CPU OUT strobe
//   out_data  in   CPU OUT value
//   in_rd     in   CPU IN consume strobe
//   in_port   out  word presented to CPU IN (holds the last value when empty)
//   in_valid  out  in_port holds an unconsumed host word
//   tx_data   out  TX FIFO head
//   tx_valid  out  TX FIFO not empty
//   tx_ready  in   host accepts tx_data
//   rx_data   in   host word for the CPU
//   rx_valid  in   rx_data valid
//   rx_ready  out  RX buffer has room
//   ovf       out  sticky TX overflow flag

module port_bridge #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             out_we,
  input  logic [WIDTH-1:0] out_data,
  input  logic             in_rd,
  output logic [WIDTH-1:0] in_port,
  output logic             in_valid,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // ---------------------------------------------------------------- TX path
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;

  logic w_pop;
  logic w_push;
  logic w_full;

  assign w_full = (r_count == FULL);
  assign w_pop  = tx_valid && tx_ready;
  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign w_push = out_we && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= out_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (out_we && !w_push) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign tx_valid = (r_count != '0);
  assign tx_data  = r_mem[r_rptr];
  assign ovf      = r_ovf;

  // ---------------------------------------------------------------- RX path
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_rx_count;

  logic w_accept;
  logic w_consume;

  // rx_ready comes from the registered count only, so in_rd never reaches it.
  assign rx_ready  = (r_rx_count < 2'd2);
  assign in_valid  = (r_rx_count != 2'd0);
  assign in_port   = r_head;
  assign w_accept  = rx_valid && rx_ready;
  assign w_consume = in_rd && in_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_rx_count <= 2'd0;
    end else begin
      // Accept implies count < 2, so at most one word is buffered here.
      if (w_accept && w_consume) begin
        r_head <= rx_data;
      end else if (w_accept) begin
        if (r_rx_count == 2'd0) begin
          r_head <= rx_data;
        end else begin
          r_tail <= rx_data;
        end
        r_rx_count <= r_rx_count + 2'd1;
      end else if (w_consume) begin
        // With one word left the head is kept so the CPU keeps reading stable data.
        if (r_rx_count == 2'd2) begin
          r_head <= r_tail;
        end
        r_rx_count <= r_rx_count - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_port_bridge.sv
// tb/tb_port_bridge.sv - directed self-checking bench for port_bridge

module tb_port_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_we;
  logic [15:0] out_data;
  logic        in_rd;
  logic [15:0] in_port;
  logic        in_valid;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  port_bridge #(.DEPTH(4), .WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .out_we   (out_we),
    .out_data (out_data),
    .in_rd    (in_rd),
    .in_port  (in_port),
    .in_valid (in_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, " tx_data"},  32'(tx_data),  32'h0);
    check({tag, " in_valid"}, 32'(in_valid), 32'd0);
    check({tag, " in_port"},  32'(in_port),  32'h0);
    check({tag, " rx_ready"}, 32'(rx_ready), 32'd1);
    check({tag, " ovf"},      32'(ovf),      32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  logic [15:0] exp_seq [4];

  initial begin
    rst      = 1'b0;
    out_we   = 1'b0;
    out_data = '0;
    in_rd    = 1'b0;
    tx_ready = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;
    #1;
    step();
    step();
    rst = 1'b1;
    check_reset_outputs("reset");

    // TX ordering with show-ahead head
    out_we = 1'b1; out_data = 16'h1111; step();
    check("tx first latency valid", 32'(tx_valid), 32'd1);
    check("tx first latency data",  32'(tx_data),  32'h1111);
    out_data = 16'h2222; step();
    out_data = 16'h3333; step();
    out_we = 1'b0;
    check("tx hold data", 32'(tx_data), 32'h1111);
    tx_ready = 1'b1;
    step();
    check("tx drain 2", 32'(tx_data), 32'h2222);
    step();
    check("tx drain 3", 32'(tx_data), 32'h3333);
    check("tx drain 3 valid", 32'(tx_valid), 32'd1);
    step();
    check("tx empty after drain", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;

    // Overflow: fifth push into a full FIFO is dropped
    out_we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      out_data = 16'hA000 + 16'(i);
      step();
      if (i == 3) check("ovf before overflow", 32'(ovf), 32'd0);
    end
    out_we = 1'b0;
    check("ovf set", 32'(ovf), 32'd1);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf drain valid %0d", i), 32'(tx_valid), 32'd1);
      check($sformatf("ovf drain data %0d", i),  32'(tx_data),  32'hA000 + i);
      step();
    end
    check("ovf drain empty", 32'(tx_valid), 32'd0);
    check("ovf sticky", 32'(ovf), 32'd1);
    tx_ready = 1'b0;

    // Full FIFO with same-cycle push and pop
    do_reset();
    check("ovf cleared by reset", 32'(ovf), 32'd0);
    out_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      out_data = 16'hC000 + 16'(i);
      step();
    end
    out_data = 16'hBEEF;
    tx_ready = 1'b1;
    step();
    out_we = 1'b0;
    check("full push+pop no ovf", 32'(ovf), 32'd0);
    exp_seq[0] = 16'hC001; exp_seq[1] = 16'hC002; exp_seq[2] = 16'hC003; exp_seq[3] = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full push+pop order %0d", i), 32'(tx_data), 32'(exp_seq[i]));
      step();
    end
    check("full push+pop empty", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;

    // RX back-pressure after two words
    rx_valid = 1'b1; rx_data = 16'h0055; step();
    rx_data = 16'h00AA; step();
    rx_data = 16'h0077; step();
    check("rx full ready", 32'(rx_ready), 32'd0);
    check("rx full in_valid", 32'(in_valid), 32'd1);
    check("rx head", 32'(in_port), 32'h0055);
    in_rd = 1'b1; step(); in_rd = 1'b0;
    check("rx promote tail", 32'(in_port), 32'h00AA);
    check("rx ready after pop", 32'(rx_ready), 32'd1);
    step();
    rx_valid = 1'b0;
    check("rx third accepted", 32'(rx_ready), 32'd0);
    in_rd = 1'b1; step();
    check("rx third word", 32'(in_port), 32'h0077);
    step();
    check("rx empty", 32'(in_valid), 32'd0);
    check("rx empty stale", 32'(in_port), 32'h0077);
    in_rd = 1'b0;

    // Underflow protection with stale hold
    rx_valid = 1'b1; rx_data = 16'h1234; step(); rx_valid = 1'b0;
    check("rx 1234 valid", 32'(in_valid), 32'd1);
    check("rx 1234 data", 32'(in_port), 32'h1234);
    in_rd = 1'b1; step();
    check("rx consumed valid", 32'(in_valid), 32'd0);
    step();
    in_rd = 1'b0;
    check("rx underflow valid", 32'(in_valid), 32'd0);
    check("rx underflow stale", 32'(in_port), 32'h1234);
    check("rx underflow ready", 32'(rx_ready), 32'd1);

    // Same-cycle accept and consume at one word
    rx_valid = 1'b1; rx_data = 16'h0101; step();
    rx_data = 16'h0202; in_rd = 1'b1; step();
    rx_valid = 1'b0; in_rd = 1'b0;
    check("rx swap data", 32'(in_port), 32'h0202);
    check("rx swap count", 32'(rx_ready), 32'd1);
    in_rd = 1'b1; step(); in_rd = 1'b0;
    check("rx swap drained", 32'(in_valid), 32'd0);

    // Reset mid-transfer, with strobes active during the reset cycle
    out_we = 1'b1; rx_valid = 1'b1;
    out_data = 16'hD001; rx_data = 16'hE001; step();
    out_data = 16'hD002; rx_data = 16'hE002; step();
    rx_valid = 1'b0;
    out_data = 16'hD003; step();
    out_we = 1'b0;
    check("pre-reset tx_valid", 32'(tx_valid), 32'd1);
    check("pre-reset in_port", 32'(in_port), 32'hE001);
    out_we = 1'b1; rx_valid = 1'b1; out_data = 16'hF00D; rx_data = 16'hF00D;
    rst = 1'b0;
    step();
    rst = 1'b1; out_we = 1'b0; rx_valid = 1'b0;
    check_reset_outputs("mid reset");
    step();
    check_reset_outputs("after mid reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
